lamp_timer_ctrl: RTL and testbench

- Parametrised successor to the three-switch staircase lamp controller.
- N_SW independent wall switches are synchronised and debounced.
- Any debounced switch change toggles or retriggers the lamp, depending on MODE. An auto-off countdown turns the lamp off after HOLD_SEC seconds.
- The remaining seconds drive a 7-segment digit and a warning flag. Sits between board switch inputs and the lamp/LED/segment outputs of the lab top level.

---
 rtl/lamp_timer_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_lamp_timer_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lamp_timer_ctrl.sv
// -----------------------------------------------------------------------------
// lamp_timer_ctrl
//   Staircase lamp controller with N_SW wall switches. Every switch is
//   synchronised and debounced; any accepted level change produces a one-cycle
//   event that toggles (MODE=0) or retriggers (MODE=1) the lamp. While lit, an
//   auto-off countdown of HOLD_SEC seconds runs; the remaining seconds drive a
//   hex 7-segment digit and a warning flag.
//
// Ports
//   clk     in   1     system clock, rising edge
//   rst_n   in   1     asynchronous active-low reset
//   sw      in   N_SW  raw asynchronous switch levels
//   F       out  1     lamp drive, 1 = on
//   remain  out  4     remaining seconds, 0 when off
//   warn    out  1     lamp on and remain <= WARN_SEC
//   evt     out  1     one-cycle pulse per accepted debounced change
//   LED     out  7     segments {g,f,e,d,c,b,a}, active-low, hex of remain
// -----------------------------------------------------------------------------
module lamp_timer_ctrl #(
    parameter int N_SW       = 3,
    parameter int DEB_CYCLES = 4,
    parameter int TICK_DIV   = 100000000,
    parameter int HOLD_SEC   = 9,
    parameter int WARN_SEC   = 3,
    parameter int MODE       = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    output logic            F,
    output logic [3:0]      remain,
    output logic            warn,
    output logic            evt,
    output logic [6:0]      LED
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int AW = $clog2(DEB_CYCLES + 3);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(DEB_CYCLES + 2);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    HOLD_VAL = 4'(HOLD_SEC);
    localparam logic [3:0]    WARN_VAL = 4'(WARN_SEC);

    typedef enum logic {ST_OFF, ST_ON} state_t;

    logic [N_SW-1:0] r_s1, r_s2;
    logic [N_SW-1:0] w_deb;
    logic [N_SW-1:0] r_deb_d;
    logic [AW-1:0]   r_arm_cnt;
    logic            r_armed;
    logic            w_evt;
    logic            w_tick;

    state_t          r_state, w_state_next;
    logic [3:0]      r_remain, w_remain_next;
    logic [PW-1:0]   r_presc, w_presc_next;

    // Two-flop synchroniser per channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    // Per-channel debounce: accept s2 after DEB_CYCLES consecutive mismatches
    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_deb
            logic [DW-1:0] r_cnt;
            logic          r_deb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_s2[gi] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == DEB_LAST) begin
                    r_deb <= r_s2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    // Change detect and arming. Arming waits until levels held through reset
    // have propagated through deb and deb_d, so they never produce an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_d   <= '0;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_deb_d <= w_deb;
            if (!r_armed) begin
                if (r_arm_cnt == ARM_LAST) begin
                    r_armed <= 1'b1;
                end else begin
                    r_arm_cnt <= r_arm_cnt + 1'b1;
                end
            end
        end
    end

    // OR-reduction of the per-bit differences: simultaneous changes on several
    // channels still give exactly one event.
    assign w_evt  = r_armed & (|(w_deb ^ r_deb_d));
    assign w_tick = (r_presc == TICK_MAX);

    // Lamp FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_OFF;
            r_remain <= 4'd0;
            r_presc  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_remain <= w_remain_next;
            r_presc  <= w_presc_next;
        end
    end

    // Lamp FSM next state; an event always takes priority over a tick.
    always_comb begin
        w_state_next  = r_state;
        w_remain_next = r_remain;
        w_presc_next  = r_presc;
        case (r_state)
            ST_OFF: begin
                w_remain_next = 4'd0;
                w_presc_next  = '0;
                if (w_evt) begin
                    w_state_next  = ST_ON;
                    w_remain_next = HOLD_VAL;
                end
            end
            ST_ON: begin
                if (w_evt) begin
                    w_presc_next = '0;
                    if (MODE == 0) begin
                        w_state_next  = ST_OFF;
                        w_remain_next = 4'd0;
                    end else begin
                        w_remain_next = HOLD_VAL;
                    end
                end else if (w_tick) begin
                    w_presc_next = '0;
                    if (r_remain == 4'd1) begin
                        w_state_next  = ST_OFF;
                        w_remain_next = 4'd0;
                    end else begin
                        w_remain_next = r_remain - 4'd1;
                    end
                end else begin
                    w_presc_next = r_presc + 1'b1;
                end
            end
            default: begin
                w_state_next  = ST_OFF;
                w_remain_next = 4'd0;
                w_presc_next  = '0;
            end
        endcase
    end

    assign F      = (r_state == ST_ON);
    assign remain = r_remain;
    assign warn   = F & (r_remain <= WARN_VAL);
    assign evt    = w_evt;

    // Active-low hex decode, blank while the lamp is off
    always_comb begin
        LED = 7'h7F;
        if (F) begin
            case (r_remain)
                4'h0: LED = 7'h40;
                4'h1: LED = 7'h79;
                4'h2: LED = 7'h24;
                4'h3: LED = 7'h30;
                4'h4: LED = 7'h19;
                4'h5: LED = 7'h12;
                4'h6: LED = 7'h02;
                4'h7: LED = 7'h78;
                4'h8: LED = 7'h00;
                4'h9: LED = 7'h10;
                4'hA: LED = 7'h08;
                4'hB: LED = 7'h03;
                4'hC: LED = 7'h46;
                4'hD: LED = 7'h21;
                4'hE: LED = 7'h06;
                default: LED = 7'h0E;
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lamp_timer_ctrl
//   Random switch activity applied to a toggle-mode and a retrigger-mode
//   instance side by side. Expected outputs come from a reference model that
//   works on the recorded switch samples (a level is accepted when a whole
//   window of samples disagrees with it) and on lamp on-times measured in
//   cycles, from which remaining seconds follow by division.
// -----------------------------------------------------------------------------
module tb_lamp_timer_ctrl;

    localparam int N_SW       = 3;
    localparam int DEB_CYCLES = 4;
    localparam int TICK_DIV   = 10;
    localparam int HOLD_SEC   = 5;
    localparam int WARN_SEC   = 2;
    localparam int N_ITER     = 6000;

    logic            clk;
    logic            rst_n;
    logic [N_SW-1:0] sw;
    logic [1:0]      f_o, warn_o, evt_o;
    logic [3:0]      remain_o [2];
    logic [6:0]      led_o    [2];

    lamp_timer_ctrl #(
        .N_SW(N_SW), .DEB_CYCLES(DEB_CYCLES), .TICK_DIV(TICK_DIV),
        .HOLD_SEC(HOLD_SEC), .WARN_SEC(WARN_SEC), .MODE(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .F(f_o[0]), .remain(remain_o[0]),
        .warn(warn_o[0]), .evt(evt_o[0]), .LED(led_o[0])
    );

    lamp_timer_ctrl #(
        .N_SW(N_SW), .DEB_CYCLES(DEB_CYCLES), .TICK_DIV(TICK_DIV),
        .HOLD_SEC(HOLD_SEC), .WARN_SEC(WARN_SEC), .MODE(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .F(f_o[1]), .remain(remain_o[1]),
        .warn(warn_o[1]), .evt(evt_o[1]), .LED(led_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low {g,f,e,d,c,b,a} hex glyphs
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int              n;          // clock edges since reset release
    bit [N_SW-1:0]   samp [$];   // samp[k] = sw seen at edge k+1
    bit [N_SW-1:0]   deb_m;
    bit              evt_m;
    bit              on_m [2];
    int              t0_m [2];   // edge at which the current on-time started
    int              n_evt;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, act, exp);
        end
    endtask

    function automatic bit [N_SW-1:0] samp_at(input int e);
        if (e >= 1 && e <= samp.size()) return samp[e-1];
        return '0;
    endfunction

    task automatic model_reset();
        n     = 0;
        samp.delete();
        deb_m = '0;
        evt_m = 1'b0;
        for (int m = 0; m < 2; m++) begin
            on_m[m] = 1'b0;
            t0_m[m] = 0;
        end
    endtask

    // Advance the model by one clock edge using the current sw value
    task automatic model_edge();
        bit [N_SW-1:0] deb_new;
        bit [N_SW-1:0] v;
        bit            differs;
        n++;
        samp.push_back(sw);
        // Lamp reacts to the event visible before this edge
        for (int m = 0; m < 2; m++) begin
            if (evt_m) begin
                if (!on_m[m]) begin
                    on_m[m] = 1'b1;
                    t0_m[m] = n;
                end else if (m == 0) begin
                    on_m[m] = 1'b0;
                end else begin
                    t0_m[m] = n;
                end
            end else if (on_m[m] && (n - t0_m[m]) >= HOLD_SEC * TICK_DIV) begin
                on_m[m] = 1'b0;
            end
        end
        // A channel flips when all samples in its window disagree with it
        deb_new = deb_m;
        for (int c = 0; c < N_SW; c++) begin
            differs = 1'b1;
            for (int k = n - DEB_CYCLES - 1; k <= n - 2; k++) begin
                v = samp_at(k);
                if (v[c] == deb_m[c]) differs = 1'b0;
            end
            if (differs) deb_new[c] = ~deb_m[c];
        end
        evt_m = (n >= DEB_CYCLES + 3) && (deb_new != deb_m);
        deb_m = deb_new;
    endtask

    task automatic check_outputs();
        int rem;
        for (int m = 0; m < 2; m++) begin
            rem = on_m[m] ? HOLD_SEC - (n - t0_m[m]) / TICK_DIV : 0;
            check_val($sformatf("m%0d.evt", m),    int'(evt_o[m]),    int'(evt_m));
            check_val($sformatf("m%0d.F", m),      int'(f_o[m]),      int'(on_m[m]));
            check_val($sformatf("m%0d.remain", m), int'(remain_o[m]), rem);
            check_val($sformatf("m%0d.warn", m),   int'(warn_o[m]),
                      int'(on_m[m] && rem <= WARN_SEC));
            check_val($sformatf("m%0d.LED", m),    int'(led_o[m]),
                      on_m[m] ? int'(glyph[rem]) : 32'h7F);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("%s.m%0d.F", tag, m),      int'(f_o[m]),      0);
            check_val($sformatf("%s.m%0d.remain", tag, m), int'(remain_o[m]), 0);
            check_val($sformatf("%s.m%0d.warn", tag, m),   int'(warn_o[m]),   0);
            check_val($sformatf("%s.m%0d.evt", tag, m),    int'(evt_o[m]),    0);
            check_val($sformatf("%s.m%0d.LED", tag, m),    int'(led_o[m]),    32'h7F);
        end
    endtask

    initial begin
        int hold_left;
        int new_sw;
        rst_n = 1'b0;
        sw    = 3'b101;
        n_evt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        // Levels held through reset must stay silent for a good while
        hold_left = 100;

        for (int it = 0; it < N_ITER; it++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            if (evt_m) begin
                n_evt++;
                $display("evt #%0d at edge %0d sw=%b lamp0=%0d lamp1=%0d",
                         n_evt, n, sw, on_m[0], on_m[1]);
            end

            // Occasional reset pulse, always including one mid-run
            if (it == N_ITER / 2 || (it > 200 && $urandom_range(0, 599) == 0)) begin
                $display("reset pulse at edge %0d lamp0=%0d lamp1=%0d", n, on_m[0], on_m[1]);
                rst_n = 1'b0;
                #1;
                check_reset_values("async_rst");
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end

            if (hold_left == 0) begin
                new_sw = int'($urandom_range(0, (1 << N_SW) - 1));
                sw = new_sw[N_SW-1:0];
                // One third short glitches, the rest long enough to be accepted
                if ($urandom_range(0, 2) == 0)
                    hold_left = int'($urandom_range(1, DEB_CYCLES - 1));
                else
                    hold_left = int'($urandom_range(DEB_CYCLES, 90));
                $display("stim edge %0d sw=%b hold=%0d", n, sw, hold_left);
                hold_left--;
            end else begin
                hold_left--;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
